// File: rtl/key_filter_if.sv
// Key pins in, debounced level and press/release pulses out.
// KEY_RELEASE_PULSE_EN adds the key_release pulse vector.
interface key_filter_if #(
    parameter int KEY_W = 2
);
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_flag;
`ifdef KEY_RELEASE_PULSE_EN
    logic [KEY_W-1:0] key_release;

    modport master (output key, input key_state, key_flag, key_release);
    modport slave  (input key, output key_state, key_flag, key_release);
`else
    modport master (output key, input key_state, key_flag);
    modport slave  (input key, output key_state, key_flag);
`endif
endinterface

// File: rtl/key_filter.sv
// Per-key synchroniser + debounce counter + press/release pulse generator.
// Optional feature macro: KEY_RELEASE_PULSE_EN (adds key_release pulses).
module key_filter_lane #(
    parameter logic [24:0] CNT_MAX = 25'd1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic state,
`ifdef KEY_RELEASE_PULSE_EN
    output logic release_p,
`endif
    output logic flag
);
    logic [1:0]  sync;
    logic [24:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
            flag  <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            release_p <= 1'b0;
`endif
        end else begin
            sync <= {sync[0], ~key_n};
            flag <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            release_p <= 1'b0;
`endif
            // Any agreement with the accepted level abandons the pending change.
            if (sync[1] == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX - 25'd1) begin
                state <= sync[1];
                cnt   <= '0;
                flag  <= sync[1];
`ifdef KEY_RELEASE_PULSE_EN
                release_p <= ~sync[1];
`endif
            end else begin
                cnt <= cnt + 25'd1;
            end
        end
    end
endmodule

module key_filter #(
    parameter logic [24:0] CNT_MAX = 25'd1_000_000,
    parameter int          KEY_W   = 2
) (
    input logic         sys_clk,
    input logic         sys_rst,
    key_filter_if.slave kif
);
    for (genvar i = 0; i < KEY_W; i++) begin : g_lane
        key_filter_lane #(.CNT_MAX(CNT_MAX)) u_lane (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key_n     (kif.key[i]),
            .state     (kif.key_state[i]),
`ifdef KEY_RELEASE_PULSE_EN
            .release_p (kif.key_release[i]),
`endif
            .flag      (kif.key_flag[i])
        );
    end
endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=25: reset, press, bounce, glitch,
// release and mid-count reset scenarios.
module tb_key_filter;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    key_filter_if #(.KEY_W(2)) kif ();

    key_filter #(.CNT_MAX(25'd25), .KEY_W(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .kif     (kif)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drive a raw level and wait long enough for it to be accepted.
    task automatic settle(input logic [1:0] k);
        kif.key = k;
        repeat (40) tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        kif.key = 2'b00;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (kif.key_state !== 2'b00 || kif.key_flag !== 2'b00) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d state=%b flag=%b want 00/00", c, kif.key_state, kif.key_flag);
            end
        end
        sys_rst = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            n_vec++;
            if (kif.key_state !== ((e >= 27) ? 2'b11 : 2'b00) ||
                kif.key_flag  !== ((e == 27) ? 2'b11 : 2'b00)) begin
                n_err++;
                $display("FAIL reset_accept e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
        end
    endtask

    task automatic test_press();
        settle(2'b11);
        n_vec++;
        if (kif.key_state !== 2'b00) begin
            n_err++;
            $display("FAIL press_pre state=%b want 00", kif.key_state);
        end
        kif.key = 2'b10;
        for (int e = 1; e <= 227; e++) begin
            tick();
            n_vec++;
            if (kif.key_state !== ((e >= 27) ? 2'b01 : 2'b00) ||
                kif.key_flag  !== ((e == 27) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL press e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
        end
    endtask

    task automatic test_bounce();
        settle(2'b11);
        for (int c = 0; c < 100; c++) begin
            kif.key = {1'b1, logic'((c / 5) % 2)};
            tick();
            n_vec++;
            if (kif.key_state !== 2'b00 || kif.key_flag !== 2'b00) begin
                n_err++;
                $display("FAIL bounce c=%0d state=%b flag=%b", c, kif.key_state, kif.key_flag);
            end
        end
        kif.key = 2'b10;
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_vec++;
            if (kif.key_flag !== ((e == 27) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL bounce_settle e=%0d flag=%b", e, kif.key_flag);
            end
        end
    endtask

    task automatic test_glitch();
        settle(2'b10);
        kif.key = 2'b00;
        repeat (24) tick();
        kif.key = 2'b10;
        for (int e = 0; e < 40; e++) begin
            n_vec++;
            if (kif.key_state !== 2'b01 || kif.key_flag !== 2'b00) begin
                n_err++;
                $display("FAIL glitch24 e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
            tick();
        end
        kif.key = 2'b00;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 25) kif.key = 2'b10;
            n_vec++;
            if (kif.key_state !== ((e >= 27) ? 2'b11 : 2'b01) ||
                kif.key_flag  !== ((e == 27) ? 2'b10 : 2'b00)) begin
                n_err++;
                $display("FAIL glitch25 e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
        end
    endtask

    task automatic test_release();
        settle(2'b11);
        settle(2'b10);
        kif.key = 2'b11;
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_vec++;
            if (kif.key_state !== ((e >= 27) ? 2'b00 : 2'b01) || kif.key_flag !== 2'b00) begin
                n_err++;
                $display("FAIL release e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
`ifdef KEY_RELEASE_PULSE_EN
            n_vec++;
            if (kif.key_release !== ((e == 27) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL release_pulse e=%0d got=%b", e, kif.key_release);
            end
`endif
        end
    endtask

    task automatic test_midcount_reset();
        settle(2'b11);
        kif.key = 2'b10;
        repeat (22) tick();
        sys_rst = 1'b0;
        tick();
        n_vec++;
        if (kif.key_state !== 2'b00 || kif.key_flag !== 2'b00) begin
            n_err++;
            $display("FAIL midreset state=%b flag=%b want 00/00", kif.key_state, kif.key_flag);
        end
        sys_rst = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            n_vec++;
            if (kif.key_state !== ((e >= 27) ? 2'b01 : 2'b00) ||
                kif.key_flag  !== ((e == 27) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL midreset_accept e=%0d state=%b flag=%b", e, kif.key_state, kif.key_flag);
            end
        end
    endtask

    initial begin
        kif.key = 2'b11;
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_release();
        test_midcount_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_filter.md
# key_filter

Debounce and edge-detect front end for the board push-buttons. Takes the raw, asynchronous, active-low key pins, synchronises them into `sys_clk`, rejects bounce shorter than `CNT_MAX` cycles, and emits a clean debounced level plus a single-cycle press pulse per key. It sits between the key pins and the key-driven LED control logic, which consumes the clean pulses instead of raw pins.

## Interface
- `CNT_MAX`, default 25'd1_000_000 (20 ms at 50 MHz): consecutive stable cycles required to accept a level change; legal range ≥ 2; benches use 25'd25
- `KEY_W`, default 2: number of independent keys
- `sys_clk`  input  1  system clock; all logic on rising edge
- `sys_rst`  input  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- `key`  input  KEY_W  raw key pins, active-low (0 = pressed), asynchronous to `sys_clk`
- `key_state`  output  KEY_W  debounced level, active-high (1 = pressed), registered
- `key_flag`  output  KEY_W  one-cycle pulse on each accepted press, registered
- `key_release`  output  KEY_W  one-cycle pulse on each accepted release; present only with `KEY_RELEASE_PULSE_EN`

## Operation
- Per key, fully independent channel: 2-flop synchroniser → mismatch counter → state register → pulse register.
- Synchroniser: `key` inverted to active-high, then two flops; output `sync[i]`.
- Counter width: enough bits for CNT_MAX-1 (25 bits at default).
- Each edge, per key:
  - `sync == key_state`: counter cleared to 0.
  - `sync != key_state` and counter < CNT_MAX-1: counter increments.
  - `sync != key_state` and counter == CNT_MAX-1: `key_state <= sync`, counter cleared; if new state is 1, `key_flag` high next cycle; if 0, `key_release` high (when compiled in).
- Effective states per key: RELEASED, PRESS_PENDING (counting while released), PRESSED, RELEASE_PENDING (counting while pressed). Any return of `sync` to `key_state` during pending drops back to the stable state and clears the counter.
- Pulses are exactly one cycle; at most one pulse per key per accepted transition; press and release pulses of one key never coincide.
- Simultaneous activity on different keys: no interaction; both pulses may assert in the same cycle.
- Counter never wraps: capped by the transition condition.

## Timing
- Reset (`sys_rst` low at an edge): synchroniser flops ← 0 (released), counters ← 0, `key_state` ← 0, `key_flag` ← 0, `key_release` ← 0. Reset asserted mid-count discards the pending transition; a key held down through reset is re-accepted after CNT_MAX+2 cycles following reset release.
- Latency: raw level first sampled at edge N → `key_state` and pulse update at edge N+CNT_MAX+1, pulse visible for the cycle after that edge only.
- Glitch rejection: any mismatch run of ≤ CNT_MAX-1 synchronised cycles produces no output change.
- Key held indefinitely: `key_state` stays 1, `key_flag` does not repeat.

## Configuration
- `KEY_RELEASE_PULSE_EN` defined: `key_release` port and its registers exist, pulse on each accepted 1→0 transition of `key_state`.
- Not defined: `key_release` port and logic absent; release still updates `key_state` with identical timing.

## Test plan
- Reset: `sys_rst`=0 for 2 cycles with `key`=2'b00 → `key_state`=0, `key_flag`=0 throughout; after release, `key`=2'b00 held → `key_state[1:0]`=2'b11 exactly 27 edges later (CNT_MAX=25), `key_flag`=2'b11 for one cycle.
- Clean press key0: `key` 2'b11→2'b10 → `key_flag[0]` single pulse 26 edges after first sampling edge, `key_flag[1]` stays 0, no repeat while held 200 cycles.
- Bounce: key0 toggles every 5 cycles for 100 cycles then settles low → no pulse during bounce, exactly one `key_flag[0]` 26 edges after last toggle is sampled.
- Glitch: key1 low for 24 synchronised cycles then high → no `key_state`/`key_flag` change; 25 cycles → accepted.
- Release with `KEY_RELEASE_PULSE_EN`: key0 pressed then released stably → `key_release[0]` one-cycle pulse 26 edges after release sampled; without macro, `key_state[0]` falls at the same edge.
- Mid-count reset: assert `sys_rst` at count 20 of a press → counter and outputs 0, no pulse; held key accepted 27 edges after reset release.
